mc_ctrl_hs: RTL
===============

// Module: mc_ctrl_hs
// PURPOSE
// Next-generation multicycle RV32I control FSM. It drives the existing multicycle datapath through the
// same control bus, and adds a ready/valid memory handshake with variable wait states.
// It also adds a watchdog timeout, an illegal-instruction trap and cycle/instret counters.
// It sits beside the datapath in the core top and replaces the fixed-latency controller.
// PARAMETERS
// CNT_W      32  width of cycle_cnt and instret_cnt; both wrap modulo 2^CNT_W
// TMO_W       4  width of the wait-state counter
// MEM_TMO    15  max wait cycles per memory access (1..2^TMO_W-1); exceeding it -> TRAP
// PORTS
// clk          in   1      clock, rising edge
// rst          in   1      synchronous reset, active-high
// Op           in   7      instr[6:0]
// F3           in   3      instr[14:12]
// F7           in   7      instr[31:25]
// Zero         in   1      ALU result == 0
// SignBit      in   1      ALU result[31]
// mem_ready    in   1      memory completes the current access this cycle
// mem_req      out  1      memory access request, held until mem_ready
// PcEn         out  1      PC write enable
// AdrSrc       out  1      0: PC, 1: AluOut as memory address
// MemWrite     out  1      store strobe, qualified by mem_req
// IrWrite      out  1      instruction/OldPC register write enable
// RegWrite     out  1      register file write enable
// ImmSrc       out  3      000 I, 001 S, 010 B, 011 J, 100 U
// AluSrcA      out  2      00 PC, 01 OldPC, 10 rs1
// AluSrcB      out  2      00 rs2, 01 imm, 10 const 4
// AluOp        out  3      000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
// ResultSrc    out  2      00 AluOut, 01 mem data, 10 ALU result, 11 imm
// trap         out  1      sticky illegal-instruction or memory-timeout flag
// cycle_cnt    out  CNT_W  cycles since reset
// instret_cnt  out  CNT_W  retired instructions
// BEHAVIOUR
// - Reset: state=FETCH; all outputs 0; counters 0; wait counter 0. Reset mid-access drops mem_req next cycle.
// - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
// - Controls not listed for a state are 0.
// - FETCH: mem_req=1, AdrSrc=0. On mem_ready: IrWrite=1, PcEn=1, ALU computes PC+4, ResultSrc=10,
//   next state DECODE. Without mem_ready the state holds.
// - DECODE: ALU computes OldPC+imm. ImmSrc is B for branches, J for JAL, else I.
//   Dispatch on Op: 0000011->MEMADR, 0100011->MEMADR, 0110011->EXR, 0010011->EXI, 1100011->BRANCH,
//   1101111->JAL, 1100111->JALR, 0110111->LUI. Any other value -> TRAP.
// - MEMADR: ALU computes rs1+imm (I for loads, S for stores) -> MEMRD or MEMWR.
// - MEMRD: mem_req=1, AdrSrc=1; on mem_ready -> MEMWB.
// - MEMWR: mem_req=1, MemWrite=1, AdrSrc=1; on mem_ready -> FETCH (retire).
// - MEMWB: RegWrite=1, ResultSrc=01 -> FETCH (retire).
// - EXR/EXI: ALU with rs1 and rs2/imm. F3 000 gives add, or sub when F7[5]=1 in EXR only.
//   F3 111 and, 110 or, 100 xor, 010 slt, 011 sltu. Other F3 (shifts) -> TRAP. Then ALUWB.
// - ALUWB: RegWrite=1, ResultSrc=00 -> FETCH (retire).
// - BRANCH: ALU computes rs1-rs2; ResultSrc=00 (target); PcEn=taken; -> FETCH (retire).
//   F3 000 beq: Zero. 001 bne: !Zero. 100 blt: SignBit. 101 bge: !SignBit. Other F3 -> TRAP.
// - JAL: RegWrite=1 with ResultSrc=00 is not used. rd<=OldPC+4 via AluSrcA=01, AluSrcB=10, ResultSrc=10.
//   PC<=AluOut target in a second cycle (JAL->ALUWB-style internal substate). Total 4 cycles + fetch wait.
// - JALR: cycle 1: rd<=OldPC+4. Cycle 2: PC<=rs1+imm (ImmSrc I, ResultSrc=10, PcEn=1). -> FETCH.
// - LUI: RegWrite=1, ResultSrc=11, ImmSrc=U -> FETCH (retire).
// - Wait counter: clears when a memory state is entered, increments on each mem_req cycle without mem_ready.
//   When it reaches MEM_TMO with mem_ready still 0 -> TRAP. mem_ready on that same cycle wins.
// - TRAP: all controls 0, trap=1, state held until rst. cycle_cnt keeps counting; instret_cnt freezes.
// - cycle_cnt increments every non-reset cycle. instret_cnt increments on the cycle a retiring state exits to FETCH.
// - Both counters wrap from all-ones to 0 with no flag.
// TESTING
// - addi x1,x0,5 with mem_ready always 1 -> FETCH,DECODE,EXI,ALUWB; RegWrite on cycle 4; instret_cnt=1.
// - lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB once; cycle_cnt=+3 vs zero-wait.
// - beq taken (Zero=1) and bne not taken (Zero=1) -> PcEn=1 in BRANCH for the first, 0 for the second.
// - Op=7'b1111111 -> trap=1 after DECODE; outputs 0; instret_cnt frozen; rst clears trap to FETCH.
// - mem_ready stuck 0 in FETCH with MEM_TMO=15 -> trap=1 after the 16th request cycle; mem_ready on cycle 16 -> no trap.
// - CNT_W=4: run 17 cycles -> cycle_cnt wraps to 1. rst asserted during MEMWR -> mem_req=0 next cycle, counters 0.

Source files
------------

// File: rtl/mc_ctrl_hs_if.sv
// mc_ctrl_hs_if: control bus between the multicycle controller and the RV32I datapath/memory
interface mc_ctrl_hs_if #(parameter int CNT_W = 32);
    logic [6:0]       Op;
    logic [2:0]       F3;
    logic [6:0]       F7;
    logic             Zero;
    logic             SignBit;
    logic             mem_ready;
    logic             mem_req;
    logic             PcEn;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IrWrite;
    logic             RegWrite;
    logic [2:0]       ImmSrc;
    logic [1:0]       AluSrcA;
    logic [1:0]       AluSrcB;
    logic [2:0]       AluOp;
    logic [1:0]       ResultSrc;
    logic             trap;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    modport master (
        input  Op, F3, F7, Zero, SignBit, mem_ready,
        output mem_req, PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc,
               AluSrcA, AluSrcB, AluOp, ResultSrc, trap, cycle_cnt, instret_cnt
    );
    modport slave (
        output Op, F3, F7, Zero, SignBit, mem_ready,
        input  mem_req, PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc,
               AluSrcA, AluSrcB, AluOp, ResultSrc, trap, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle RV32I control FSM with ready/valid memory handshake, watchdog and counters
module mc_ctrl_hs #(
    parameter int CNT_W   = 32,
    parameter int TMO_W   = 4,
    parameter int MEM_TMO = 15
) (
    input logic          clk,
    input logic          rst,
    mc_ctrl_hs_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXR, EXI,
        ALUWB, BRANCH, JAL, JALR, LUI, TRAP
    } state_t;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    state_t           state, nxt;
    logic             ph;
    logic [TMO_W-1:0] wcnt;
    logic [CNT_W-1:0] cyc, ins;
    logic [2:0]       alu_f;
    logic             alu_ok, br_ok, taken, mem_st, tmo, retire;
    always_comb begin
        alu_ok = 1'b1;
        alu_f  = 3'b000;
        case (bus.F3)
            3'b000:  alu_f = (state == EXR && bus.F7[5]) ? 3'b001 : 3'b000;
            3'b111:  alu_f = 3'b010;
            3'b110:  alu_f = 3'b011;
            3'b100:  alu_f = 3'b100;
            3'b010:  alu_f = 3'b101;
            3'b011:  alu_f = 3'b110;
            default: alu_ok = 1'b0;
        endcase
    end
    assign br_ok  = bus.F3 inside {3'b000, 3'b001, 3'b100, 3'b101};
    assign taken  = bus.F3[2] ? (bus.SignBit ^ bus.F3[0]) : (bus.Zero ^ bus.F3[0]);
    assign mem_st = state inside {FETCH, MEMRD, MEMWR};
    // a ready arriving on the last allowed wait cycle still completes the access
    assign tmo    = mem_st && !bus.mem_ready && wcnt == TMO_W'(MEM_TMO);
    always_comb begin
        nxt = state;
        case (state)
            FETCH:    nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE:   nxt = bus.Op == OP_LD || bus.Op == OP_ST ? MEMADR :
                            bus.Op == OP_R    ? EXR    :
                            bus.Op == OP_I    ? EXI    :
                            bus.Op == OP_B    ? BRANCH :
                            bus.Op == OP_JAL  ? JAL    :
                            bus.Op == OP_JALR ? JALR   :
                            bus.Op == OP_LUI  ? LUI    : TRAP;
            MEMADR:   nxt = bus.Op == OP_ST ? MEMWR : MEMRD;
            MEMRD:    nxt = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:    nxt = bus.mem_ready ? FETCH : MEMWR;
            EXR, EXI: nxt = alu_ok ? ALUWB : TRAP;
            BRANCH:   nxt = br_ok ? FETCH : TRAP;
            JAL:      nxt = ph ? FETCH : JAL;
            JALR:     nxt = ph ? FETCH : JALR;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
        if (tmo) nxt = TRAP;
    end
    // only retiring states ever hand control back to FETCH
    assign retire = nxt == FETCH && state != FETCH;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            ph    <= 1'b0;
            wcnt  <= '0;
            cyc   <= '0;
            ins   <= '0;
        end else begin
            state <= nxt;
            ph    <= (state == JAL || state == JALR) && !ph;
            wcnt  <= (mem_st && !bus.mem_ready) ? wcnt + 1'b1 : '0;
            cyc   <= cyc + 1'b1;
            if (retire) ins <= ins + 1'b1;
        end
    end
    assign bus.cycle_cnt   = cyc;
    assign bus.instret_cnt = ins;
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.PcEn      = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IrWrite   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ImmSrc    = 3'b000;
        bus.AluSrcA   = 2'b00;
        bus.AluSrcB   = 2'b00;
        bus.AluOp     = 3'b000;
        bus.ResultSrc = 2'b00;
        bus.trap      = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.IrWrite   = bus.mem_ready;
                    bus.PcEn      = bus.mem_ready;
                    bus.AluSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                DECODE: begin
                    bus.AluSrcA = 2'b01;
                    bus.AluSrcB = 2'b01;
                    bus.ImmSrc  = bus.Op == OP_B ? 3'b010 : bus.Op == OP_JAL ? 3'b011 : 3'b000;
                end
                MEMADR: begin
                    bus.AluSrcA = 2'b10;
                    bus.AluSrcB = 2'b01;
                    bus.ImmSrc  = bus.Op == OP_ST ? 3'b001 : 3'b000;
                end
                MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.AdrSrc  = 1'b1;
                end
                MEMWR: begin
                    bus.mem_req  = 1'b1;
                    bus.MemWrite = 1'b1;
                    bus.AdrSrc   = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite  = 1'b1;
                    bus.ResultSrc = 2'b01;
                end
                EXR, EXI: begin
                    bus.AluSrcA = alu_ok ? 2'b10 : 2'b00;
                    bus.AluSrcB = alu_ok && state == EXI ? 2'b01 : 2'b00;
                    bus.AluOp   = alu_ok ? alu_f : 3'b000;
                end
                ALUWB: bus.RegWrite = 1'b1;
                BRANCH: begin
                    bus.AluSrcA = 2'b10;
                    bus.AluOp   = 3'b001;
                    bus.PcEn    = br_ok && taken;
                end
                JAL, JALR: begin
                    bus.RegWrite  = !ph;
                    bus.PcEn      = ph;
                    bus.AluSrcA   = ph ? (state == JALR ? 2'b10 : 2'b00) : 2'b01;
                    bus.AluSrcB   = ph ? (state == JALR ? 2'b01 : 2'b00) : 2'b10;
                    bus.ResultSrc = ph && state == JAL ? 2'b00 : 2'b10;
                end
                LUI: begin
                    bus.RegWrite  = 1'b1;
                    bus.ResultSrc = 2'b11;
                    bus.ImmSrc    = 3'b100;
                end
                TRAP: bus.trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
